fact_bus_master: RTL

- Bus-master sequencer on the master side of BUS; drives m_req/m_wr/m_addr/m_dout and consumes m_grant/m_din.
- On a start pulse, writes an operand into the factorial core's register window and kicks it off.
- Then polls the core's status word until done, reads back the 128-bit result, and reports it to the host logic.

---
 rtl/fact_bus_pkg.sv | 42 ++++
 rtl/fact_bus_rdcap.sv | 42 ++++
 rtl/fact_bus_master.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/fact_bus_pkg.sv
// Shared definitions for the factorial-core bus master: register map,
// command constants and the sequencer state encoding.
package fact_bus_pkg;

  localparam logic [15:0] OFS_OPERAND  = 16'd0;
  localparam logic [15:0] OFS_START    = 16'd1;
  localparam logic [15:0] OFS_STATUS   = 16'd2;
  localparam logic [15:0] OFS_RESULT_H = 16'd3;
  localparam logic [15:0] OFS_RESULT_L = 16'd4;

  localparam logic [63:0] START_CMD       = 64'h1;
  localparam int          STATUS_DONE_BIT = 0;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_REQ   = 4'd1,
    ST_WR_GO = 4'd2,
    ST_RD_ST = 4'd3,
    ST_W_ST  = 4'd4,
    ST_RD_H  = 4'd5,
    ST_W_H   = 4'd6,
    ST_RD_L  = 4'd7,
    ST_W_L   = 4'd8,
    ST_DONE  = 4'd9,
    ST_TMO   = 4'd10
  } state_t;

  // Wait states keep presenting the address of the read they are waiting on.
  function automatic logic [15:0] state_ofs(state_t s);
    logic [15:0] ofs;
    case (s)
      ST_REQ:           ofs = OFS_OPERAND;
      ST_WR_GO:         ofs = OFS_START;
      ST_RD_ST, ST_W_ST: ofs = OFS_STATUS;
      ST_RD_H, ST_W_H:  ofs = OFS_RESULT_H;
      ST_RD_L, ST_W_L:  ofs = OFS_RESULT_L;
      default:          ofs = 16'd0;
    endcase
    return ofs;
  endfunction

endpackage

// File: rtl/fact_bus_rdcap.sv
// Read-data capture: delays a read launch by RD_LAT edges and captures m_din.
// 'word' bypasses the incoming data during the capture cycle so the
// sequencer can act on it at the same edge it is stored.
module fact_bus_rdcap #(
  parameter int RD_LAT = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        launch,
  input  logic [63:0] din,
  output logic        valid,
  output logic [63:0] word
);

  logic [RD_LAT-1:0] pipe_r;
  logic [63:0]       data_r;

  assign valid = pipe_r[RD_LAT-1];
  assign word  = valid ? din : data_r;

  // Launch delay line; bit RD_LAT-1 marks the edge where m_din is valid.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pipe_r <= '0;
    end else begin
      pipe_r    <= pipe_r << 1;
      pipe_r[0] <= launch;
    end
  end

  // Capture register holding the most recent read word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_r <= 64'h0;
    end else if (valid) begin
      data_r <= din;
    end else begin
      data_r <= data_r;
    end
  end

endmodule

// File: rtl/fact_bus_master.sv
// Bus-master sequencer: loads an operand into the factorial core, starts it,
// polls STATUS until done (or timeout) and reads back the 128-bit result.
module fact_bus_master
  import fact_bus_pkg::*;
#(
  parameter logic [15:0] CORE_BASE = 16'h7000,
  parameter int          RD_LAT    = 1,
  parameter int          MAX_POLL  = 1024
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic [63:0]   operand,
  output logic          busy,
  output logic          done,
  output logic          timeout,
  output logic [127:0]  result,
  output logic          m_req,
  output logic          m_wr,
  output logic [15:0]   m_addr,
  output logic [63:0]   m_dout,
  input  logic          m_grant,
  input  logic [63:0]   m_din
);

  localparam int PW = $clog2(MAX_POLL + 1);

  state_t        state_r, next_s;
  logic [63:0]   operand_r;
  logic [PW-1:0] poll_r;
  logic          fire_s, launch_s, cap_valid_s;
  logic [63:0]   cap_word_s;
  logic          req_s, wr_s;
  logic [15:0]   addr_s;
  logic [63:0]   dout_s;

  assign fire_s   = m_req && m_grant;
  assign launch_s = fire_s && (state_r inside {ST_RD_ST, ST_RD_H, ST_RD_L});

  fact_bus_rdcap #(.RD_LAT(RD_LAT)) u_rdcap (
    .clk     (clk),
    .reset_n (reset_n),
    .launch  (launch_s),
    .din     (m_din),
    .valid   (cap_valid_s),
    .word    (cap_word_s)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_s;
    end
  end

  // Next-state logic and the bus values to present in the next cycle.
  always_comb begin
    next_s = state_r;
    case (state_r)
      ST_IDLE:  next_s = start       ? ST_REQ   : ST_IDLE;
      ST_REQ:   next_s = fire_s      ? ST_WR_GO : ST_REQ;
      ST_WR_GO: next_s = fire_s      ? ST_RD_ST : ST_WR_GO;
      ST_RD_ST: next_s = fire_s      ? ST_W_ST  : ST_RD_ST;
      ST_W_ST: begin
        if (!cap_valid_s) begin
          next_s = ST_W_ST;
        end else if (cap_word_s[STATUS_DONE_BIT]) begin
          next_s = ST_RD_H;
        end else if (poll_r == PW'(MAX_POLL)) begin
          next_s = ST_TMO;
        end else begin
          next_s = ST_RD_ST;
        end
      end
      ST_RD_H:  next_s = fire_s      ? ST_W_H   : ST_RD_H;
      ST_W_H:   next_s = cap_valid_s ? ST_RD_L  : ST_W_H;
      ST_RD_L:  next_s = fire_s      ? ST_W_L   : ST_RD_L;
      ST_W_L:   next_s = cap_valid_s ? ST_DONE  : ST_W_L;
      ST_DONE:  next_s = ST_IDLE;
      ST_TMO:   next_s = ST_IDLE;
      default:  next_s = ST_IDLE;
    endcase

    req_s  = next_s inside {ST_REQ, ST_WR_GO, ST_RD_ST, ST_W_ST,
                            ST_RD_H, ST_W_H, ST_RD_L, ST_W_L};
    wr_s   = next_s inside {ST_REQ, ST_WR_GO};
    addr_s = req_s ? (CORE_BASE + state_ofs(next_s)) : 16'd0;
    case (next_s)
      ST_REQ:   dout_s = (state_r == ST_IDLE) ? operand : operand_r;
      ST_WR_GO: dout_s = START_CMD;
      default:  dout_s = 64'h0;
    endcase
  end

  // Registered bus/host outputs, operand latch, poll counter and result.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_req     <= 1'b0;
      m_wr      <= 1'b0;
      m_addr    <= 16'd0;
      m_dout    <= 64'h0;
      busy      <= 1'b0;
      done      <= 1'b0;
      timeout   <= 1'b0;
      result    <= 128'h0;
      operand_r <= 64'h0;
      poll_r    <= '0;
    end else begin
      m_req  <= req_s;
      m_wr   <= wr_s;
      m_addr <= addr_s;
      m_dout <= dout_s;
      busy   <= (next_s != ST_IDLE);
      done   <= (next_s == ST_DONE) || (next_s == ST_TMO);
      if (state_r == ST_IDLE && start) begin
        operand_r <= operand;
        poll_r    <= '0;
        result    <= 128'h0;
        timeout   <= 1'b0;
      end else begin
        if (state_r == ST_RD_ST && fire_s && poll_r != PW'(MAX_POLL)) begin
          poll_r <= poll_r + PW'(1);
        end
        if (state_r == ST_W_H && cap_valid_s) begin
          result[127:64] <= cap_word_s;
        end
        if (state_r == ST_W_L && cap_valid_s) begin
          result[63:0] <= cap_word_s;
        end
        if (next_s == ST_TMO) begin
          timeout <= 1'b1;
          result  <= 128'h0;
        end
      end
    end
  end

endmodule
